// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle 8-bit shift sequencer.
// Accepts one command (op, amt, operand) per start/done handshake and applies
// amt single-bit steps, one per clock, via a per-bit 4:1 select
// (hold / left neighbour / right neighbour / fill-or-wrap).
module shift_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] amt,
  input  logic [7:0] d_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out
);

  localparam int unsigned W      = 8;
  localparam int unsigned AMT_W  = 3;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_LSL = 2'b00;
  localparam logic [OP_W-1:0] OP_LSR = 2'b01;
  localparam logic [OP_W-1:0] OP_ASR = 2'b10;
  localparam logic [OP_W-1:0] OP_ROR = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_FILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state;
  logic [W-1:0]       q;
  logic [AMT_W-1:0]   cnt;
  logic [OP_W-1:0]    op_r;

  logic [W-1:0][1:0]  sel;
  logic [W-1:0]       left_nb;
  logic [W-1:0]       right_nb;
  logic [W-1:0]       fill;
  logic               fill_msb;
  logic [W-1:0]       step;

  // Neighbour and fill vectors; bit i's left neighbour is q[i+1], right is q[i-1].
  always_comb begin
    left_nb  = {1'b0, q[W-1:1]};
    right_nb = {q[W-2:0], 1'b0};
    fill_msb = 1'b0;
    case (op_r)
      OP_ASR:  fill_msb = q[W-1];
      OP_ROR:  fill_msb = q[0];
      default: fill_msb = 1'b0;
    endcase
    fill = {fill_msb, (W-1)'(0)};
  end

  // Per-bit select generation: hold outside SHIFT, otherwise driven by op_r.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      sel[i] = SEL_HOLD;
      if (state == SHIFT) begin
        case (op_r)
          OP_LSL:  sel[i] = (i == 0)     ? SEL_FILL : SEL_RIGHT;
          OP_LSR,
          OP_ASR,
          OP_ROR:  sel[i] = (i == W - 1) ? SEL_FILL : SEL_LEFT;
          default: sel[i] = SEL_HOLD;
        endcase
      end
    end
  end

  // Per-bit 4:1 datapath mux producing the next working-register value.
  always_comb begin
    step = q;
    for (int i = 0; i < W; i++) begin
      case (sel[i])
        SEL_LEFT:  step[i] = left_nb[i];
        SEL_RIGHT: step[i] = right_nb[i];
        SEL_FILL:  step[i] = fill[i];
        default:   step[i] = q[i];
      endcase
    end
  end

  // Control FSM with operand/result register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      op_r  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q    <= d_in;
            op_r <= op;
            cnt  <= amt;
            busy <= 1'b1;
            if (amt == AMT_W'(0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          q   <= step;
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out = q;

endmodule

// File: tb/tb_shift_seq8.sv
// Scoreboard bench for shift_seq8: stimulus pushes expected results, a
// monitor pops and compares whenever done is presented.
module tb_shift_seq8;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [2:0] amt;
  logic [7:0] d_in;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];

  shift_seq8 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .d_in  (d_in),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got d_out=0x%0h expected no done", d_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (d_out !== e) begin
          failures++;
          $display("FAIL result: got 0x%0h expected 0x%0h", d_out, e);
        end
      end
    end
  end

  // Issue one command and check handshake timing; optionally poke start while busy.
  task automatic run_cmd(input logic [1:0] o, input logic [2:0] a,
                         input logic [7:0] din, input logic [7:0] e,
                         input string nm, input bit pulse);
    int k, done_at, busy_cnt, ndone;
    @(negedge clk);
    start = 1'b1; op = o; amt = a; d_in = din;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; d_in = 8'h00;
    k = 1; done_at = 0; busy_cnt = 0; ndone = 0;
    while (busy && k <= 20) begin
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      busy_cnt++;
      start = 1'b0;
      if (pulse && (k == 2 || k == int'(a) + 1)) begin
        start = 1'b1; op = 2'b01; d_in = 8'h00;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k > 20) begin
      checks++; failures++;
      $display("FAIL %s_timeout: busy still high after 20 cycles", nm);
    end
    chk({nm, "_done_lat"}, done_at, int'(a) + 1);
    chk({nm, "_busy_cycles"}, busy_cnt, int'(a) + 1);
    chk({nm, "_done_pulses"}, ndone, 1);
    chk({nm, "_held"}, int'(d_out), int'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dout", int'(d_out), 8'h00);
    reset = 1'b0;

    run_cmd(2'b00, 3'd3, 8'hB5, 8'hA8, "lsl_b5_3", 1'b0);
    run_cmd(2'b10, 3'd2, 8'h96, 8'hE5, "asr_96_2", 1'b0);
    run_cmd(2'b10, 3'd7, 8'h96, 8'hFF, "asr_96_7", 1'b0);
    run_cmd(2'b11, 3'd1, 8'h81, 8'hC0, "ror_81_1", 1'b0);
    run_cmd(2'b11, 3'd7, 8'h01, 8'h02, "ror_01_7", 1'b0);
    run_cmd(2'b01, 3'd0, 8'h5A, 8'h5A, "lsr_5a_0", 1'b0);
    run_cmd(2'b01, 3'd7, 8'h80, 8'h01, "lsr_80_7", 1'b0);

    // Start pulses during SHIFT and DONE are dropped, not queued.
    run_cmd(2'b00, 3'd5, 8'hFF, 8'hE0, "lsl_ff_5_ign", 1'b1);
    @(negedge clk);
    chk("ignored_not_queued_busy", int'(busy), 0);
    chk("ignored_not_queued_dout", int'(d_out), 8'hE0);

    // Reset after the second step aborts the command.
    @(negedge clk);
    start = 1'b1; op = 2'b00; amt = 3'd6; d_in = 8'hB5;
    exp_q.push_back(8'h00);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_two_steps", int'(d_out), 8'hD4);
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dout", int'(d_out), 8'h00);
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done || busy) nd++;
      end
      chk("abort_no_done", nd, 0);
    end

    run_cmd(2'b01, 3'd3, 8'h80, 8'h10, "lsr_80_3", 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
# shift_seq8

Multi-cycle shift sequencer for the 8-bit shifter datapath. It accepts a shift command (operation, amount, operand) through a start/done handshake and executes it as a sequence of single-bit steps, one step per clock. Each step is a per-bit 4:1 selection between neighbour bits, fill bits and hold. The block sits between a command source (test controller or upper-level FSM) and the shifter datapath, and owns the operand/result register.

## Interface

- No parameters; width fixed at 8 bits, amount at 3 bits.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  command request; sampled only in IDLE
- op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR
- amt  input  3  shift amount 0..7
- d_in  input  8  operand, captured with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- d_out  output  8  working/result register; valid when done is high, held until next accepted start

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures d_in into q, op into op_r, amt into cnt.
  - If amt==0, next state is DONE; otherwise next state is SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one step per cycle, q <= step(q, op_r) and cnt <= cnt-1. The step functions are:
  - LSL: {q[6:0],1'b0}
  - LSR: {1'b0,q[7:1]}
  - ASR: {q[7],q[7:1]}
  - ROR: {q[0],q[7:1]}
- SHIFT exit: when cnt==1 on a step, next state is DONE. Exactly amt steps are applied.
- DONE: done=1 for exactly one cycle, q unchanged; next state is IDLE unconditionally.
- Per-bit select, one 4:1 choice per bit per step:
  - 00 hold
  - 01 left neighbour
  - 10 right neighbour
  - 11 fill/wrap bit
  - Select is 00 in every state except SHIFT.
- op_r, cnt and q are used internally only. op and amt are not re-sampled during a command.
- start while busy=1 (SHIFT or DONE) is ignored, not queued.
- d_out = q at all times.
- busy = (state != IDLE).
- done = (state == DONE).

## Timing

- Reset (synchronous, has priority over all other inputs): state=IDLE, q=8'h00, cnt=0, op_r=00, busy=0, done=0, d_out=8'h00.
- Reset mid-operation aborts the command. The next cycle shows busy=0, done=0, d_out=8'h00, and no done pulse follows.
- Latency: let E0 be the edge that accepts start.
  - busy rises after E0.
  - done is high in the cycle following edge E0+amt (for amt=0, the cycle right after E0).
  - busy falls one edge after done.
- Throughput: one command per amt+2 cycles. A new start is accepted no earlier than the first IDLE cycle after done.
- Holding start high continuously produces back-to-back commands separated by exactly one IDLE cycle.
- d_out changes only on the capture edge and on SHIFT edges. It is stable during DONE and IDLE.
- Boundary cases:
  - amt=7 with LSL or LSR leaves only 1 original bit.
  - ROR amt=7 equals rotate-left by 1.
  - ASR never changes bit 7.

## Test plan

- Reset then LSL, d_in=8'hB5, amt=3: busy high 4 cycles, done 3 cycles after capture edge, d_out=8'hA8.
- ASR, d_in=8'h96, amt=2: d_out=8'hE5. Repeat with d_in=8'h96, amt=7: d_out=8'hFF.
- ROR, d_in=8'h81, amt=1: d_out=8'hC0. Then ROR, d_in=8'h01, amt=7: d_out=8'h02.
- LSR, d_in=8'h5A, amt=0: done in the cycle right after capture, d_out=8'h5A, busy for 1 cycle. Then LSR, d_in=8'h80, amt=7: d_out=8'h01.
- LSL, d_in=8'hFF, amt=5, and pulse start with d_in=8'h00, op=01 during SHIFT and again during DONE: both ignored, d_out=8'hE0, exactly one done pulse.
- LSL, d_in=8'hB5, amt=6, with reset asserted after the 2nd step: next cycle busy=0, done=0, d_out=8'h00, and no done pulse within 10 cycles. A following LSR 8'h80 amt=3 yields 8'h10.
